// File: rtl/scan_pkg.sv
// Shared constants, state encoding and word-slice helper for the scan chain sequencer.
package scan_pkg;

  localparam int DATA_LENG = 100;
  localparam int WORD_W    = 16;
  localparam int N_WORDS   = 7;
  localparam int TAIL_W    = DATA_LENG - (N_WORDS - 1) * WORD_W;

  localparam logic [2:0] LAST_WORD = 3'(N_WORDS - 1);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    STOP    = 3'd1,
    ARM     = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    UNLOAD  = 3'd5
  } state_t;

  // The last word only carries the TAIL_W leftover bits, zero-extended.
  function automatic logic [WORD_W-1:0] word_slice(input logic [DATA_LENG-1:0] vec,
                                                   input logic [2:0] k);
    logic [WORD_W-1:0] w;
    w = '0;
    if (k < LAST_WORD) w = vec[{k, 4'b0000} +: WORD_W];
    else               w = {{(WORD_W - TAIL_W){1'b0}}, vec[DATA_LENG-1 -: TAIL_W]};
    return w;
  endfunction

endpackage

// File: rtl/sync2_edge.sv
// Two-flop synchronizer for a slow cross-domain flag, plus a one-cycle rising-edge pulse.
module sync2_edge (
  input  logic clki,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge clki) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise = s2 & ~s2_d;

endmodule

// File: rtl/scan_chain_sequencer.sv
// Packs host words into a scan vector, sequences the driver enables, and unpacks the result.
module scan_chain_sequencer
  import scan_pkg::*;
#(
  parameter int ENB_HOLD = 10000000,
  parameter int HOLD_W   = 26
) (
  input  logic                 clki,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_LENG-1:0] SC_vec,
  output logic                 SC_clk_enb,
  output logic                 SC_data_enb,
  input  logic                 SC_done,
  input  logic [DATA_LENG-1:0] SC_out,
  output logic [WORD_W-1:0]    out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  state_t               state, state_n;
  logic [2:0]           idx, idx_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_n;
  logic [DATA_LENG-1:0] result, result_n;
  logic [DATA_LENG-1:0] vec_n;
  logic [WORD_W-1:0]    out_word_n;
  logic                 in_ready_n, clk_enb_n, data_enb_n, out_valid_n, busy_n;
  logic                 done_rise;

  sync2_edge u_done_sync (
    .clki (clki),
    .rst  (rst),
    .din  (SC_done),
    .rise (done_rise)
  );

  always_ff @(posedge clki) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      hold_cnt    <= '0;
      result      <= '0;
      SC_vec      <= '0;
      in_ready    <= 1'b0;
      SC_clk_enb  <= 1'b1;
      SC_data_enb <= 1'b1;
      out_word    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      hold_cnt    <= hold_n;
      result      <= result_n;
      SC_vec      <= vec_n;
      in_ready    <= in_ready_n;
      SC_clk_enb  <= clk_enb_n;
      SC_data_enb <= data_enb_n;
      out_word    <= out_word_n;
      out_valid   <= out_valid_n;
      busy        <= busy_n;
    end
  end

  // Every output is registered, so each branch sets the values seen in the following state.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    hold_n      = hold_cnt;
    result_n    = result;
    vec_n       = SC_vec;
    in_ready_n  = in_ready;
    clk_enb_n   = SC_clk_enb;
    data_enb_n  = SC_data_enb;
    out_word_n  = out_word;
    out_valid_n = out_valid;
    busy_n      = busy;

    case (state)
      LOAD: begin
        in_ready_n = 1'b1;
        clk_enb_n  = 1'b1;
        data_enb_n = 1'b1;
        busy_n     = 1'b0;
        if (in_valid && in_ready) begin
          if (idx == LAST_WORD) begin
            vec_n[DATA_LENG-1 -: TAIL_W] = in_word[TAIL_W-1:0];
            idx_n      = '0;
            in_ready_n = 1'b0;
            busy_n     = 1'b1;
            state_n    = STOP;
          end else begin
            vec_n[{idx, 4'b0000} +: WORD_W] = in_word;
            idx_n = idx + 3'd1;
          end
        end
      end

      STOP: begin
        clk_enb_n = 1'b0;
        hold_n    = '0;
        state_n   = ARM;
      end

      // Hold data_enb high long enough for at least one scan-clock negedge to clear the driver.
      ARM: begin
        if (hold_cnt == HOLD_W'(ENB_HOLD - 1)) begin
          hold_n     = '0;
          data_enb_n = 1'b0;
          state_n    = RUN;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end

      RUN: begin
        if (done_rise) state_n = CAPTURE;
      end

      CAPTURE: begin
        result_n    = SC_out;
        out_word_n  = word_slice(SC_out, 3'd0);
        out_valid_n = 1'b1;
        idx_n       = '0;
        state_n     = UNLOAD;
      end

      UNLOAD: begin
        if (out_valid && out_ready) begin
          if (idx == LAST_WORD) begin
            out_valid_n = 1'b0;
            out_word_n  = '0;
            clk_enb_n   = 1'b1;
            data_enb_n  = 1'b1;
            busy_n      = 1'b0;
            in_ready_n  = 1'b1;
            idx_n       = '0;
            state_n     = LOAD;
          end else begin
            idx_n      = idx + 3'd1;
            out_word_n = word_slice(result, idx + 3'd1);
          end
        end
      end

      default: state_n = LOAD;
    endcase
  end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Self-checking bench: sequencer against a behavioural M=8 loopback scan driver, scoreboard on unload.
module tb_scan_chain_sequencer;

  logic         clki = 1'b0;
  logic         rst;
  logic [15:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [99:0]  SC_vec;
  logic         SC_clk_enb;
  logic         SC_data_enb;
  logic         SC_done;
  logic [99:0]  SC_out;
  logic [15:0]  out_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int           total = 0;
  int           bad = 0;
  int           cycle_no = 0;
  int           stop_cycle = 0;
  logic [15:0]  words [7];
  logic [15:0]  exp_q [$];

  scan_chain_sequencer #(.ENB_HOLD(16), .HOLD_W(26)) dut (
    .clki        (clki),
    .rst         (rst),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SC_vec      (SC_vec),
    .SC_clk_enb  (SC_clk_enb),
    .SC_data_enb (SC_data_enb),
    .SC_done     (SC_done),
    .SC_out      (SC_out),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clki = ~clki;

  always @(posedge clki) cycle_no <= cycle_no + 1;

  // Behavioural driver: scan clock of 8 clki cycles, one bit shifted per scan negedge, SC_data looped to data_out.
  logic [2:0]  drv_div = 3'd0;
  logic [6:0]  drv_bit = 7'd0;
  logic        drv_done = 1'b0;
  logic [99:0] drv_out = '0;

  always @(posedge clki) begin
    if (SC_clk_enb) begin
      drv_div <= 3'd0;
    end else begin
      drv_div <= drv_div + 3'd1;
      if (drv_div == 3'd7) begin
        if (SC_data_enb) begin
          drv_bit  <= 7'd0;
          drv_done <= 1'b0;
        end else if (!drv_done) begin
          drv_out <= {drv_out[98:0], SC_vec[drv_bit]};
          drv_bit <= drv_bit + 7'd1;
          if (drv_bit == 7'd99) drv_done <= 1'b1;
        end
      end
    end
  end

  assign SC_done = drv_done;
  assign SC_out  = drv_out;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [99:0] pack_words();
    logic [99:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[16*k +: 16] = words[k];
    v[99:96] = words[6][3:0];
    return v;
  endfunction

  // Bits go out LSB first and enter data_out at its LSB, so the result is the load vector reversed.
  function automatic logic [99:0] reverse_vec(input logic [99:0] v);
    logic [99:0] r;
    for (int i = 0; i < 100; i++) r[99-i] = v[i];
    return r;
  endfunction

  task automatic applyStimulus(input bit toggle);
    int          k;
    int          cyc;
    logic        v;
    logic        acc;
    logic [99:0] ref_vec;
    k   = 0;
    cyc = 0;
    while (k < 7 && cyc < 100) begin
      v        = toggle ? (cyc % 3 != 1) : 1'b1;
      in_valid = v;
      in_word  = v ? words[k] : 16'($urandom);
      acc      = v && in_ready;
      @(negedge clki);
      cyc++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    stop_cycle = cycle_no;
    checkOutput("load_count", 128'(k), 128'd7);
    checkOutput("in_ready_drop", 128'(in_ready), 128'd0);
    checkOutput("sc_vec", 128'(SC_vec), 128'(pack_words()));
    ref_vec = reverse_vec(pack_words());
    exp_q.delete();
    for (int j = 0; j < 6; j++) exp_q.push_back(ref_vec[16*j +: 16]);
    exp_q.push_back({12'h000, ref_vec[99:96]});
  endtask

  task automatic collectOutput(input bit bp, input bit chk_gap);
    int   n;
    int   cyc;
    int   stall;
    bit   seen;
    n     = 0;
    cyc   = 0;
    stall = 0;
    seen  = 0;
    while (n < 7 && cyc < 3000) begin
      if (out_valid && !seen) begin
        seen = 1;
        if (chk_gap) checkOutput("stale_gap", 128'((cycle_no - stop_cycle) >= 17), 128'd1);
      end
      if (bp && n == 3 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        checkOutput("hold_w3", 128'(out_word), 128'(exp_q[0]));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        checkOutput("unload", 128'(out_word), 128'(exp_q.pop_front()));
        n++;
      end
      @(negedge clki);
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("word_count", 128'(n), 128'd7);
    checkOutput("busy_after", 128'(busy), 128'd0);
    checkOutput("valid_after", 128'(out_valid), 128'd0);
    checkOutput("clk_enb_after", 128'(SC_clk_enb), 128'd1);
    checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic random_words();
    for (int k = 0; k < 7; k++) words[k] = 16'($urandom);
  endtask

  // Data-enable must stay high for exactly 16 cycles after the clock enable falls, every run.
  initial begin
    int   arm_cnt;
    logic prev_data;
    arm_cnt   = 0;
    prev_data = 1'b1;
    forever begin
      @(negedge clki);
      if (!rst && !SC_clk_enb && prev_data && !SC_data_enb)
        checkOutput("arm_len", 128'(arm_cnt), 128'd16);
      if (SC_clk_enb) arm_cnt = 0;
      else if (SC_data_enb) arm_cnt++;
      prev_data = SC_data_enb;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle_no);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clki);
    checkOutput("rst_clk_enb", 128'(SC_clk_enb), 128'd1);
    checkOutput("rst_data_enb", 128'(SC_data_enb), 128'd1);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    @(negedge clki);
    checkOutput("in_ready_rise", 128'(in_ready), 128'd1);

    $display("[TB] run 1: fixed pattern");
    words = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h1234, 16'hDEAD, 16'hBEEF, 16'hFFF9};
    applyStimulus(1'b0);
    checkOutput("sc_vec_const", 128'(SC_vec), 128'(100'h9_BEEF_DEAD_1234_A5A5_0000_FFFF));
    checkOutput("busy_load", 128'(busy), 128'd1);
    collectOutput(1'b0, 1'b0);

    $display("[TB] run 2: back-to-back with stale done, toggled valid, backpressure");
    random_words();
    applyStimulus(1'b1);
    collectOutput(1'b1, 1'b1);

    $display("[TB] run 3: reset during RUN");
    random_words();
    applyStimulus(1'b0);
    cyc = 0;
    while ((SC_clk_enb || SC_data_enb) && cyc < 200) begin
      @(negedge clki);
      cyc++;
    end
    checkOutput("reach_run", 128'(!SC_clk_enb && !SC_data_enb), 128'd1);
    repeat (40) @(negedge clki);
    rst = 1'b1;
    @(negedge clki);
    checkOutput("mid_clk_enb", 128'(SC_clk_enb), 128'd1);
    checkOutput("mid_data_enb", 128'(SC_data_enb), 128'd1);
    checkOutput("mid_out_valid", 128'(out_valid), 128'd0);
    checkOutput("mid_busy", 128'(busy), 128'd0);
    checkOutput("mid_sc_vec", 128'(SC_vec), 128'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clki);

    $display("[TB] run 4: full run after reset");
    random_words();
    applyStimulus(1'b0);
    collectOutput(1'b0, 1'b1);

    repeat (3) @(negedge clki);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
